// File: rtl/ld_st_issue_queue_pkg.sv
// Shared types for the load/store issue queue: CDB broadcast, dispatch
// payload, and the head payload handed to the memory issue unit.
// Tag 0 is reserved as "no tag" and never matches a CDB broadcast.
package ld_st_issue_queue_pkg;

    localparam int DATA_W    = 32;
    localparam int IMM_W     = 16;
    localparam int TAG_WIDTH = 6;

    localparam logic [TAG_WIDTH-1:0] NO_TAG = '0;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } ld_st_opcode_e;

    typedef struct packed {
        logic                 cdb_valid;
        logic [TAG_WIDTH-1:0] cdb_tag;
        logic [DATA_W-1:0]    cdb_result;
    } cdb_bfm;

    typedef struct packed {
        ld_st_opcode_e        opcode;
        logic [TAG_WIDTH-1:0] rs1_tag;
        logic                 rs1_valid;
        logic [DATA_W-1:0]    rs1_data;
        logic [TAG_WIDTH-1:0] rs2_tag;
        logic                 rs2_valid;
        logic [DATA_W-1:0]    rs2_data;
        logic [TAG_WIDTH-1:0] rd_tag;
        logic [IMM_W-1:0]     immediate;
    } ld_st_dispatch_data;

    typedef struct packed {
        logic [DATA_W-1:0]    rs1_data;
        logic [DATA_W-1:0]    rs2_data;
        logic [TAG_WIDTH-1:0] rd_tag;
        logic [IMM_W-1:0]     immediate;
        ld_st_opcode_e        ld_st_opcode;
    } ld_st_fifo_data;

    // A live broadcast that names this (non-reserved) tag.
    function automatic logic cdb_hit(cdb_bfm c, logic [TAG_WIDTH-1:0] t);
        return c.cdb_valid && (c.cdb_tag != NO_TAG) && (c.cdb_tag == t);
    endfunction

endpackage

// File: rtl/ld_st_issue_queue_if.sv
// Issue handshake between the load/store queue (master) and the memory
// issue unit (slave). The slave has no back-pressure: it pops with
// read_enable whenever it sees issue_queue_rdy.
interface ld_st_issue_queue_if;
    import ld_st_issue_queue_pkg::*;

    logic           issue_queue_rdy;
    logic           read_enable;
    ld_st_fifo_data mem_exec_fifo_data;

    modport master (
        output issue_queue_rdy,
        output mem_exec_fifo_data,
        input  read_enable
    );

    modport slave (
        input  issue_queue_rdy,
        input  mem_exec_fifo_data,
        output read_enable
    );
endinterface

// File: rtl/ld_st_operand_snoop.sv
// One source operand slot of a queue entry: holds tag/valid/data, captures
// the CDB result when its pending tag is broadcast, and resolves the case
// where the operand is dispatched in the same cycle its producer broadcasts.
// Optional macro: LD_ST_CDB_BYPASS_EN - the ready/data outputs also reflect
// a matching broadcast in the current cycle (combinational bypass).
module ld_st_operand_snoop
    import ld_st_issue_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 entry_vld,
    input  logic [TAG_WIDTH-1:0] disp_tag,
    input  logic                 disp_valid,
    input  logic [DATA_W-1:0]    disp_data,
    input  cdb_bfm               cdb,
    output logic                 ready,
    output logic [DATA_W-1:0]    data
);

    logic [TAG_WIDTH-1:0] tag_q;
    logic                 valid_q;
    logic [DATA_W-1:0]    data_q;
    logic                 disp_hit;
    logic                 snoop_hit;

    assign disp_hit  = !disp_valid && cdb_hit(cdb, disp_tag);
    assign snoop_hit = entry_vld && !valid_q && cdb_hit(cdb, tag_q);

    // Operand register: flush > dispatch write > CDB capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= NO_TAG;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr) begin
            valid_q <= 1'b0;
        end else if (load) begin
            tag_q   <= disp_tag;
            valid_q <= disp_valid || disp_hit;
            data_q  <= disp_hit ? cdb.cdb_result : disp_data;
        end else if (snoop_hit) begin
            valid_q <= 1'b1;
            data_q  <= cdb.cdb_result;
        end
    end

`ifdef LD_ST_CDB_BYPASS_EN
    // Forward this cycle's broadcast so the head can issue without waiting.
    always_comb begin
        ready = valid_q || snoop_hit;
        data  = snoop_hit ? cdb.cdb_result : data_q;
    end
`else
    // Stored state only: a capture becomes visible the cycle after broadcast.
    always_comb begin
        ready = valid_q;
        data  = data_q;
    end
`endif

endmodule

// File: rtl/ld_st_issue_queue.sv
// In-order load/store issue queue. Dispatched entries wait in a circular
// buffer, snoop the CDB for pending operands, and the head is offered to the
// memory issue unit once its operands are ready (loads need rs1, stores need
// rs1 and rs2). Younger ready entries never bypass the head.
// Optional macro: LD_ST_CDB_BYPASS_EN - head readiness includes a matching
// CDB broadcast in the same cycle (handled inside ld_st_operand_snoop).
module ld_st_issue_queue
    import ld_st_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_WIDTH   // must equal the package tag width
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         dispatch_en,
    input  ld_st_dispatch_data           dispatch_data,
    input  cdb_bfm                       cdb,
    ld_st_issue_queue_if.master          iq,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]              head;
    logic [PTR_W-1:0]              tail;
    logic [DEPTH-1:0]              ent_vld;
    logic [DEPTH-1:0]              is_store;
    logic [DEPTH-1:0][TAG_W-1:0]   rd_tag_q;
    logic [DEPTH-1:0][IMM_W-1:0]   imm_q;

    logic [DEPTH-1:0]              wr_sel;
    logic [DEPTH-1:0]              rs1_rdy;
    logic [DEPTH-1:0]              rs2_rdy;
    logic [DEPTH-1:0][DATA_W-1:0]  rs1_data;
    logic [DEPTH-1:0][DATA_W-1:0]  rs2_data;

    logic push;
    logic pop;
    logic head_rdy;

    // Dispatch is blocked while full even if the head pops this cycle.
    assign push = dispatch_en && !full && !flush;
    assign pop  = iq.read_enable && head_rdy && !flush;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_ent
            assign wr_sel[i] = push && (tail == PTR_W'(i));

            ld_st_operand_snoop u_rs1 (
                .clk        (clk),
                .rst_n      (rst_n),
                .clr        (flush),
                .load       (wr_sel[i]),
                .entry_vld  (ent_vld[i]),
                .disp_tag   (dispatch_data.rs1_tag),
                .disp_valid (dispatch_data.rs1_valid),
                .disp_data  (dispatch_data.rs1_data),
                .cdb        (cdb),
                .ready      (rs1_rdy[i]),
                .data       (rs1_data[i])
            );

            ld_st_operand_snoop u_rs2 (
                .clk        (clk),
                .rst_n      (rst_n),
                .clr        (flush),
                .load       (wr_sel[i]),
                .entry_vld  (ent_vld[i]),
                .disp_tag   (dispatch_data.rs2_tag),
                .disp_valid (dispatch_data.rs2_valid),
                .disp_data  (dispatch_data.rs2_data),
                .cdb        (cdb),
                .ready      (rs2_rdy[i]),
                .data       (rs2_data[i])
            );
        end
    endgenerate

    // Entry valid bits, non-operand payload and circular pointers.
    // Push and pop never target the same slot: tail==head only when the
    // queue is empty (no pop) or full (no push).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            ent_vld  <= '0;
            is_store <= '0;
            rd_tag_q <= '0;
            imm_q    <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            ent_vld <= '0;
        end else begin
            if (push) begin
                ent_vld[tail]  <= 1'b1;
                is_store[tail] <= (dispatch_data.opcode == OP_STORE);
                rd_tag_q[tail] <= dispatch_data.rd_tag;
                imm_q[tail]    <= dispatch_data.immediate;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Head readiness: loads need rs1 only, stores need both operands.
    always_comb begin
        head_rdy = ent_vld[head] && rs1_rdy[head] &&
                   (!is_store[head] || rs2_rdy[head]);
    end

    // Head payload to the memory issue unit; zeros when the head is empty.
    always_comb begin
        iq.issue_queue_rdy    = head_rdy;
        iq.mem_exec_fifo_data = '0;
        if (ent_vld[head]) begin
            iq.mem_exec_fifo_data.rs1_data     = rs1_data[head];
            iq.mem_exec_fifo_data.rs2_data     = rs2_data[head];
            iq.mem_exec_fifo_data.rd_tag       = rd_tag_q[head];
            iq.mem_exec_fifo_data.immediate    = imm_q[head];
            iq.mem_exec_fifo_data.ld_st_opcode = is_store[head] ? OP_STORE : OP_LOAD;
        end
    end

endmodule

// File: tb/tb_ld_st_issue_queue.sv
// Self-checking bench for ld_st_issue_queue: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model. Issued
// payloads go through a scoreboard consumed by an independent monitor.
module tb_ld_st_issue_queue;
    import ld_st_issue_queue_pkg::*;

    localparam int DEPTH = 4;
`ifdef LD_ST_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               dispatch_en = 1'b0;
    ld_st_dispatch_data dd = '0;
    cdb_bfm             cdb = '0;
    logic               full;
    logic               empty;
    logic [2:0]         count;

    ld_st_issue_queue_if iq_if ();

    ld_st_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .dispatch_en   (dispatch_en),
        .dispatch_data (dd),
        .cdb           (cdb),
        .iq            (iq_if.master),
        .full          (full),
        .empty         (empty),
        .count         (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: an ordered list of in-flight instructions.
    typedef struct {
        bit          st;
        logic [5:0]  t1;
        bit          v1;
        logic [31:0] d1;
        logic [5:0]  t2;
        bit          v2;
        logic [31:0] d2;
        logic [5:0]  rd;
        logic [15:0] imm;
    } ment_t;

    ment_t          mq[$];
    ld_st_fifo_data sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit live(cdb_bfm c, logic [5:0] t);
        return c.cdb_valid && (c.cdb_tag != 6'd0) && (c.cdb_tag == t);
    endfunction

    function automatic ld_st_dispatch_data mk(bit st, logic [5:0] t1, bit v1, logic [31:0] d1,
                                              logic [5:0] t2, bit v2, logic [31:0] d2,
                                              logic [5:0] rd, logic [15:0] imm);
        ld_st_dispatch_data d;
        d.opcode    = st ? OP_STORE : OP_LOAD;
        d.rs1_tag   = t1;
        d.rs1_valid = v1;
        d.rs1_data  = d1;
        d.rs2_tag   = t2;
        d.rs2_valid = v2;
        d.rs2_data  = d2;
        d.rd_tag    = rd;
        d.immediate = imm;
        return d;
    endfunction

    function automatic cdb_bfm mkc(bit v, logic [5:0] t, logic [31:0] r);
        cdb_bfm c;
        c.cdb_valid  = v;
        c.cdb_tag    = t;
        c.cdb_result = r;
        return c;
    endfunction

    function automatic ld_st_dispatch_data rnd_dd();
        logic [5:0] t1 = 6'($urandom_range(0, 7));
        logic [5:0] t2 = 6'($urandom_range(0, 7));
        bit v1 = (t1 == 6'd0) ? 1'b1 : 1'($urandom_range(0, 1));
        bit v2 = (t2 == 6'd0) ? 1'b1 : 1'($urandom_range(0, 1));
        return mk(1'($urandom_range(0, 1)), t1, v1, $urandom(), t2, v2, $urandom(),
                  6'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)));
    endfunction

    // Compare all outputs for the current inputs; queue the expected payload
    // when an issue is expected this cycle. Returns the expected readiness.
    task automatic check_outputs(output bit r);
        ld_st_fifo_data e = '0;
        r = 1'b0;
        if (mq.size() > 0) begin
            ment_t h = mq[0];
            bit b1 = BYP && !h.v1 && live(cdb, h.t1);
            bit b2 = BYP && !h.v2 && live(cdb, h.t2);
            r = (h.v1 || b1) && (!h.st || h.v2 || b2);
            e.rs1_data     = b1 ? cdb.cdb_result : h.d1;
            e.rs2_data     = b2 ? cdb.cdb_result : h.d2;
            e.rd_tag       = h.rd;
            e.immediate    = h.imm;
            e.ld_st_opcode = h.st ? OP_STORE : OP_LOAD;
        end
        chk("issue_queue_rdy", iq_if.issue_queue_rdy, r);
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        if (mq.size() == 0) begin
            chk("data_when_empty", iq_if.mem_exec_fifo_data, 0);
        end else begin
            chk("head_rd_tag", iq_if.mem_exec_fifo_data.rd_tag, e.rd_tag);
            chk("head_imm", iq_if.mem_exec_fifo_data.immediate, e.immediate);
        end
        if (r && iq_if.read_enable) sb.push_back(e);
    endtask

    // Apply one clock edge of the architectural rules to the model.
    task automatic model_update(input bit fl, input bit de, input ld_st_dispatch_data d,
                                input cdb_bfm c, input bit popped);
        bit was_full = (mq.size() == DEPTH);
        ment_t n;
        if (fl) begin
            mq.delete();
            return;
        end
        foreach (mq[i]) begin
            if (!mq[i].v1 && live(c, mq[i].t1)) begin mq[i].v1 = 1'b1; mq[i].d1 = c.cdb_result; end
            if (!mq[i].v2 && live(c, mq[i].t2)) begin mq[i].v2 = 1'b1; mq[i].d2 = c.cdb_result; end
        end
        if (popped) void'(mq.pop_front());
        if (de && !was_full) begin
            n.st  = (d.opcode == OP_STORE);
            n.t1  = d.rs1_tag;
            n.v1  = d.rs1_valid || live(c, d.rs1_tag);
            n.d1  = (!d.rs1_valid && live(c, d.rs1_tag)) ? c.cdb_result : d.rs1_data;
            n.t2  = d.rs2_tag;
            n.v2  = d.rs2_valid || live(c, d.rs2_tag);
            n.d2  = (!d.rs2_valid && live(c, d.rs2_tag)) ? c.cdb_result : d.rs2_data;
            n.rd  = d.rd_tag;
            n.imm = d.immediate;
            mq.push_back(n);
        end
    endtask

    task automatic step(input bit fl, input bit de, input ld_st_dispatch_data d,
                        input cdb_bfm c, input bit re);
        bit r;
        @(negedge clk);
        flush = fl;
        dispatch_en = de;
        dd = d;
        cdb = c;
        iq_if.read_enable = re;
        #1;
        check_outputs(r);
        @(posedge clk);
        model_update(fl, de, d, c, re && r);
    endtask

    task automatic idle(input bit re);
        step(1'b0, 1'b0, '0, '0, re);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rdy"}, iq_if.issue_queue_rdy, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_data"}, iq_if.mem_exec_fifo_data, 0);
    endtask

    // Monitor: every issue the DUT presents must match the scoreboard head.
    initial begin
        ld_st_fifo_data got;
        ld_st_fifo_data exp;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && iq_if.issue_queue_rdy && iq_if.read_enable) begin
                got = iq_if.mem_exec_fifo_data;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got %0h expected no issue at %0t", got, $time);
                end else begin
                    exp = sb.pop_front();
                    chk("issue_payload", got, exp);
                end
            end
        end
    end

    initial begin
        iq_if.read_enable = 1'b0;
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Ready load issues the cycle after dispatch, then pops.
        step(0, 1, mk(0, 6'd0, 1, 32'h100, 6'd0, 1, 32'h0, 6'd5, 16'd4), '0, 0);
        idle(1);
        idle(0);

        // Store waiting on rs2 tag 7.
        step(0, 1, mk(1, 6'd0, 1, 32'h20, 6'd7, 0, 32'h0, 6'd6, 16'd8), '0, 0);
        idle(1);
        step(0, 0, '0, mkc(1, 6'd7, 32'hDEAD), 1);
        idle(1);
        idle(1);

        // In-order: a ready younger entry waits behind the head on tag 3.
        step(0, 1, mk(0, 6'd3, 0, 32'h0, 6'd0, 1, 32'h0, 6'd1, 16'd1), '0, 0);
        step(0, 1, mk(0, 6'd0, 1, 32'h44, 6'd0, 1, 32'h0, 6'd2, 16'd2), '0, 1);
        idle(1);
        step(0, 0, '0, mkc(1, 6'd3, 32'h3333), 1);
        idle(1);
        idle(1);
        idle(1);

        // Fill to DEPTH, drop the 5th, then pop+dispatch at count 3.
        for (int i = 0; i < 5; i++)
            step(0, 1, mk(0, 6'd0, 1, 32'(i), 6'd0, 1, 32'h0, 6'(10 + i), 16'(i)), '0, 0);
        idle(1);
        step(0, 1, mk(0, 6'd0, 1, 32'h55, 6'd0, 1, 32'h0, 6'd20, 16'd9), '0, 1);
        for (int i = 0; i < 5; i++) idle(1);

        // Dispatch/CDB collision on tag 9; CDB tag 0 never captures.
        step(0, 1, mk(0, 6'd9, 0, 32'h0, 6'd0, 1, 32'h0, 6'd21, 16'd3), mkc(1, 6'd9, 32'h9999), 0);
        idle(1);
        step(0, 1, mk(0, 6'd0, 0, 32'h0, 6'd0, 1, 32'h0, 6'd22, 16'd5), mkc(1, 6'd0, 32'hBAD), 0);
        step(0, 0, '0, mkc(1, 6'd0, 32'hBAD0), 1);
        idle(1);

        // Flush together with dispatch clears everything.
        for (int i = 0; i < 3; i++)
            step(0, 1, mk(0, 6'd4, 0, 32'h0, 6'd0, 1, 32'h0, 6'(30 + i), 16'(i)), '0, 0);
        step(1, 1, mk(0, 6'd0, 1, 32'h1, 6'd0, 1, 32'h0, 6'd40, 16'd0), '0, 1);
        idle(1);

        // Randomized traffic with an asynchronous reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                @(negedge clk);
                flush = 1'b0;
                dispatch_en = 1'b0;
                cdb = '0;
                iq_if.read_enable = 1'b0;
                #3;
                rst_n = 1'b0;
                #1;
                check_reset_values("async_reset");
                mq.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 6), rnd_dd(),
                 mkc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom()),
                 ($urandom_range(0, 9) < 7));
        end
        idle(0);
        idle(0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
